alu_instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the 3-stage pipelined ALU (`pipeline_top`). Holds a bench-loadable instruction memory, walks it with a program counter, and presents one `{opcode, a, b}` triple per cycle to the ALU under a valid/ready handshake. Stops on a halt opcode or at the end of memory, and reports progress through `busy`, `done` and an issue counter.

---
 rtl/alu_instr_fetch.sv | 163 ++++++++++++++++
 tb/tb_alu_instr_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_fetch.sv
// alu_instr_fetch: instruction fetch stage feeding the pipelined ALU.
// Walks instr_mem with a program counter and issues one {opcode, a, b}
// triple per cycle under a valid/ready handshake. Fetch stops on HALT_OP
// or at the end of memory.
// Build option: define FETCH_LOOP_EN to wrap past the last entry and keep
// fetching, so that only HALT_OP or reset ends fetch.
module alu_instr_fetch #(
  parameter int unsigned     WIDTH   = 8,
  parameter int unsigned     DEPTH   = 16,
  parameter int unsigned     ADDR_W  = 4,
  parameter logic [WIDTH-1:0] HALT_OP = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  opcode,
  output logic [WIDTH-1:0]  a,
  output logic [WIDTH-1:0]  b,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [7:0]        issued_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Program store; loaded externally by name, never reset.
  logic [3*WIDTH-1:0] instr_mem [0:DEPTH-1];

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   opcode_q, opcode_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [7:0]         issued_cnt_q, issued_cnt_d;

  logic [3*WIDTH-1:0] fetch_word_s;
  logic [WIDTH-1:0]   fetch_op_s;
  logic               handshake_s;
  logic               slot_free_s;
  logic               last_entry_s;

  assign fetch_word_s = instr_mem[pc_q];
  assign fetch_op_s   = fetch_word_s[3*WIDTH-1 -: WIDTH];
  assign handshake_s  = out_valid_q && out_ready;
  assign slot_free_s  = !out_valid_q || out_ready;
  assign last_entry_s = (pc_q == ADDR_W'(DEPTH - 1));

  // Next-state, program counter, output triple and issue counter
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    out_valid_d  = out_valid_q;
    opcode_d     = opcode_q;
    a_d          = a_q;
    b_d          = b_q;
    issued_cnt_d = issued_cnt_q;

    // Every completed handshake counts, including the drain in DONE.
    if (handshake_s && (issued_cnt_q != 8'hFF)) begin
      issued_cnt_d = issued_cnt_q + 8'd1;
    end else begin
      issued_cnt_d = issued_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d         = '0;
          issued_cnt_d = 8'd0;
          state_d      = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH: begin
        if (!slot_free_s) begin
          // Downstream stalled: hold everything.
          state_d = ST_FETCH;
        end else if (fetch_op_s == HALT_OP) begin
          // Halt is never issued; pc stays on the halt entry.
          out_valid_d = 1'b0;
          state_d     = ST_DONE;
        end else begin
          opcode_d    = fetch_op_s;
          a_d         = fetch_word_s[2*WIDTH-1 -: WIDTH];
          b_d         = fetch_word_s[WIDTH-1:0];
          out_valid_d = 1'b1;
          pc_d        = pc_q + ADDR_W'(1);
`ifdef FETCH_LOOP_EN
          state_d     = ST_FETCH;
`else
          if (last_entry_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
`endif
        end
      end

      ST_DONE: begin
        if (handshake_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
        // Restart only once the last issued triple has drained.
        if (start && !out_valid_q) begin
          pc_d         = '0;
          issued_cnt_d = 8'd0;
          state_d      = ST_FETCH;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      out_valid_q  <= 1'b0;
      opcode_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      issued_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      out_valid_q  <= out_valid_d;
      opcode_q     <= opcode_d;
      a_q          <= a_d;
      b_q          <= b_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign opcode     = opcode_q;
  assign a          = a_q;
  assign b          = b_q;
  assign pc         = pc_q;
  assign issued_cnt = issued_cnt_q;
  assign busy       = (state_q == ST_FETCH);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_instr_fetch.sv
// Directed bench for alu_instr_fetch; expectations follow the build macro
// FETCH_LOOP_EN for the end-of-memory case.
module tb_alu_instr_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] pc;
  logic       busy;
  logic       done;
  logic [7:0] issued_cnt;

  int checks_total  = 0;
  int checks_passed = 0;

  alu_instr_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .opcode     (opcode),
    .a          (a),
    .b          (b),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .issued_cnt (issued_cnt)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input int idx, input logic [7:0] op, input logic [7:0] va, input logic [7:0] vb);
    dut.instr_mem[idx] = {op, va, vb};
  endtask

  task automatic check_triple(input string tag, input logic [23:0] exp);
    check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_val({tag, "_triple"}, 32'({opcode, a, b}), 32'(exp));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) set_mem(i, 8'h00, 8'h00, 8'h00);
    set_mem(0, 8'h01, 8'h05, 8'h03);
    set_mem(1, 8'h02, 8'h09, 8'h04);
    set_mem(2, 8'hFF, 8'h00, 8'h00);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_triple", 32'({opcode, a, b}), 32'd0);
    check_val("rst_pc", 32'(pc), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_cnt", 32'(issued_cnt), 32'd0);

    // Halt-terminated program, out_ready held high
    pulse_start();                       // edge k
    check_val("t1_busy_k", 32'(busy), 32'd1);
    check_val("t1_valid_k", 32'(out_valid), 32'd0);
    check_val("t1_pc_k", 32'(pc), 32'd0);
    tick();                              // k+1
    check_triple("t1_k1", 24'h010503);
    check_val("t1_pc_k1", 32'(pc), 32'd1);
    tick();                              // k+2
    check_triple("t1_k2", 24'h020904);
    check_val("t1_cnt_k2", 32'(issued_cnt), 32'd1);
    tick();                              // k+3
    check_val("t1_valid_k3", 32'(out_valid), 32'd0);
    check_val("t1_done_k3", 32'(done), 32'd1);
    check_val("t1_cnt_k3", 32'(issued_cnt), 32'd2);
    check_val("t1_pc_k3", 32'(pc), 32'd2);

    // Restart from DONE, then backpressure on the first triple
    pulse_start();
    check_val("t2_cnt_clr", 32'(issued_cnt), 32'd0);
    check_val("t2_pc_clr", 32'(pc), 32'd0);
    check_val("t2_busy", 32'(busy), 32'd1);
    out_ready = 1'b0;
    tick();
    check_triple("t2_first", 24'h010503);
    for (int i = 0; i < 3; i++) begin
      start = (i == 1) ? 1'b1 : 1'b0;    // start in FETCH must be ignored
      tick();
      check_triple("t2_stall", 24'h010503);
      check_val("t2_stall_pc", 32'(pc), 32'd1);
      check_val("t2_stall_cnt", 32'(issued_cnt), 32'd0);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    check_triple("t2_next", 24'h020904);
    check_val("t2_next_cnt", 32'(issued_cnt), 32'd1);
    tick();
    check_val("t2_done", 32'(done), 32'd1);
    check_val("t2_cnt_end", 32'(issued_cnt), 32'd2);

    // Reset asserted while the second triple is valid
    pulse_start();
    tick();
    tick();
    check_triple("t3_second", 24'h020904);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("t3_valid", 32'(out_valid), 32'd0);
    check_val("t3_triple", 32'({opcode, a, b}), 32'd0);
    check_val("t3_pc", 32'(pc), 32'd0);
    check_val("t3_busy", 32'(busy), 32'd0);
    check_val("t3_done", 32'(done), 32'd0);
    tick();
    tick();
    check_val("t3_idle_valid", 32'(out_valid), 32'd0);
    check_val("t3_idle_busy", 32'(busy), 32'd0);

    // Halt in entry 0: no issue at all
    set_mem(0, 8'hFF, 8'h00, 8'h00);
    pulse_start();
    check_val("t4_valid_k", 32'(out_valid), 32'd0);
    tick();
    check_val("t4_done", 32'(done), 32'd1);
    check_val("t4_valid", 32'(out_valid), 32'd0);
    check_val("t4_cnt", 32'(issued_cnt), 32'd0);
    check_val("t4_pc", 32'(pc), 32'd0);

    // End of memory: 16 non-halt entries
    for (int i = 0; i < 16; i++) set_mem(i, 8'(i + 1), 8'(8'h10 + i), 8'(8'h20 + i));
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      tick();
      check_triple("t5_issue", {8'(i + 1), 8'(8'h10 + i), 8'(8'h20 + i)});
      check_val("t5_cnt", 32'(issued_cnt), 32'(i));
      if (i < 15) check_val("t5_busy", 32'(busy), 32'd1);
    end
    check_val("t5_pc_wrap", 32'(pc), 32'd0);
    tick();
`ifdef FETCH_LOOP_EN
    check_triple("t5_loop17", 24'h011020);
    check_val("t5_loop_busy", 32'(busy), 32'd1);
    check_val("t5_loop_cnt", 32'(issued_cnt), 32'd16);
`else
    check_val("t5_valid_end", 32'(out_valid), 32'd0);
    check_val("t5_done_end", 32'(done), 32'd1);
    check_val("t5_cnt_end", 32'(issued_cnt), 32'd16);
    check_val("t5_pc_end", 32'(pc), 32'd0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
